switch_bounce_gen: RTL
======================

# switch_bounce_gen

Synchronous model of a single-pole double-throw mechanical switch. It drives the two active-low contact lines `a` and `b` that our SR-latch debouncer consumes. On each throw request it produces break-before-make contact motion with a programmable transit time and an LFSR-randomised train of bounces on the closing contact. It is used as the stimulus end of the debouncer in FPGA self-test and in simulation benches, and it keeps its own count of completed throws so results can be cross-checked against the debouncer's counter.

## Interface
- `TRANSIT_CYCLES`, default 16: cycles with both contacts open during a throw; must be at least 1.
- `SETTLE_CYCLES`, default 8: cycles the closing contact is held stable-closed before the throw completes; must be at least 1.
- `BOUNCES`, default 4: open/close bounce pairs per throw when bounces are enabled; range 0–15.
- `BOUNCE_W`, default 4: width of the random bounce-length field; range 1–16.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. A seed of 0 is replaced by 1.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: throw request, sampled only in IDLE.
- `bounce_en` in 1: enables bounces; sampled together with `start`.
- `a` out 1: contact A. 0 means closed, 1 means open.
- `b` out 1: contact B. 0 means closed, 1 means open.
- `pos` out 1: settled position. 0 means A is closed, 1 means B is closed.
- `busy` out 1: a throw is in progress.
- `done` out 1: one-cycle pulse when a throw completes.
- `throws` out 4: count of completed throws, wraps modulo 16.

## Operation
- All outputs are registered.
- Reset values: `a`=0, `b`=1, `pos`=0, `busy`=0, `done`=0, `throws`=0, FSM in IDLE, LFSR = seed.
- The opening contact is the contact currently closed. The closing contact is the other one.
- FSM states and transitions:
  - IDLE: on `start`, the opening contact goes to 1, `busy` goes to 1, bounce enable is latched, and the FSM moves to TRANSIT.
  - TRANSIT: both contacts are 1 for `TRANSIT_CYCLES` cycles. Then the closing contact goes to 0. The next state is BNC_CLOSED if bounces are enabled and `BOUNCES`>0; otherwise SETTLE.
  - BNC_CLOSED: the closing contact is held at 0 for L cycles, then goes to 1 and the FSM moves to BNC_OPEN.
  - BNC_OPEN: the closing contact is held at 1 for L cycles, then goes to 0. The bounce counter increments. If it has reached `BOUNCES` the FSM moves to SETTLE; otherwise back to BNC_CLOSED.
  - SETTLE: the closing contact is held at 0 for `SETTLE_CYCLES` cycles. Then `pos` toggles, `throws` increments, `done` pulses, `busy` clears, and the FSM returns to IDLE.
- Bounce length L is the LFSR's low `BOUNCE_W` bits, with 0 mapped to 1. It is sampled on entry to each bounce state.
- LFSR: 16-bit Galois, mask 16'hB400, advancing every cycle from reset.
- Invariant: `a` and `b` are never both 0.
- Boundary conditions:
  - `start` while `busy` is ignored and is not queued.
  - `bounce_en` changing mid-throw has no effect.
  - `throws` wraps from 15 to 0.
  - Reset asserted mid-throw returns every output to its reset value asynchronously; the partial throw is not counted.

## Timing
- With `start` sampled at edge k:
  - The opening contact is 1 after edge k.
  - The closing contact is 0 after edge k+`TRANSIT_CYCLES`.
  - Without bounces, `done`=1, `busy`=0 and `pos` toggled all appear after edge k+`TRANSIT_CYCLES`+`SETTLE_CYCLES`.
- Bounces extend the throw by the sum of 2·`BOUNCES` L values. Each L is between 1 and 2^`BOUNCE_W`−1.
- A new `start` is accepted on the edge after `done` at the earliest, since the FSM is back in IDLE.

## Structure
- Package `switch_gen_pkg` contains:
  - the state enum (IDLE, TRANSIT, BNC_CLOSED, BNC_OPEN, SETTLE);
  - the LFSR mask constant;
  - the contact level constants CLOSED=0 and OPEN=1.
- Sub-module `lfsr16`, with ports clk, rst_n, seed, and q[15:0]. It is free-running.
- The top level contains the FSM, a 16-bit phase counter, a 4-bit bounce counter, and the output registers.

## Test plan
- Reset check: assert `rst_n`=0 → `a`=0, `b`=1, `pos`=0, `busy`=0, `throws`=0.
- Throw without bounces, using defaults with `bounce_en`=0 and one `start` pulse at edge k:
  - `a` rises after edge k;
  - `a`=`b`=1 for 16 cycles;
  - `b` falls after edge k+16;
  - `done` after edge k+24, with `pos`=1 and `throws`=1.
- Throw with bounces, `bounce_en`=1 and `BOUNCES`=4:
  - exactly 5 falling edges on `b`;
  - `a` stays 1 throughout;
  - `a`&`b` never both 0;
  - the final `b`=0 holds for 8 cycles before `done`.
- Request handling: `start` held high for the whole throw → exactly one throw. Then 16 throws → `throws` wraps to 0 and `pos` returns to 0.
- Reset mid-throw: `rst_n` pulsed low during BNC_OPEN → outputs return to reset values immediately; the next `start` performs a normal throw from A to B.
- Closed-loop check, generator connected to the debouncer, 10 throws with bounces → the debouncer's counter advances by exactly 10 and matches `throws`.

Source files
------------

// File: rtl/switch_gen_pkg.sv
// ============================================================================
// switch_gen_pkg : shared types and constants for the switch bounce generator
// Revision: 1.0
// ============================================================================
`default_nettype none

package switch_gen_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TRANSIT    = 3'd1,
    BNC_CLOSED = 3'd2,
    BNC_OPEN   = 3'd3,
    SETTLE     = 3'd4
  } state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Contact lines are active-low: a closed contact pulls its line to 0.
  localparam logic CLOSED = 1'b0;
  localparam logic OPEN   = 1'b1;

  // Bounce length from the low WIDTH bits of the LFSR; a zero field becomes 1.
  function automatic logic [15:0] bounce_len(input logic [15:0] q,
                                             input int unsigned width);
    logic [15:0] mask;
    logic [15:0] len;
    mask = (width >= 16) ? 16'hFFFF : ((16'h0001 << width) - 16'h0001);
    len  = q & mask;
    if (len == 16'h0000) begin
      len = 16'h0001;
    end
    return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/switch_bounce_gen_lfsr16.sv
// ============================================================================
// lfsr16 : free-running 16-bit Galois LFSR, restarts from seed on reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module lfsr16
  import switch_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [15:0] seed_safe;

  // An all-zero state would lock up, so a zero seed is forced to 1.
  always_comb begin
    seed_safe = (seed == 16'h0000) ? 16'h0001 : seed;
    lfsr_d    = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_MASK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= seed_safe;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/switch_bounce_gen.sv
// ============================================================================
// switch_bounce_gen : SPDT switch model with break-before-make and LFSR bounce
// Revision: 1.0
// ============================================================================
`default_nettype none

module switch_bounce_gen
  import switch_gen_pkg::*;
#(
  parameter int          TRANSIT_CYCLES = 16,
  parameter int          SETTLE_CYCLES  = 8,
  parameter int          BOUNCES        = 4,
  parameter int          BOUNCE_W       = 4,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       bounce_en,
  output logic       a,
  output logic       b,
  output logic       pos,
  output logic       busy,
  output logic       done,
  output logic [3:0] throws
);

  localparam logic [15:0] TRANSIT_LOAD = 16'(TRANSIT_CYCLES - 1);
  localparam logic [15:0] SETTLE_LOAD  = 16'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  BOUNCES_N    = 4'(BOUNCES);

  state_t      state_q, state_d;
  logic [15:0] phase_q, phase_d;
  logic [3:0]  bnc_cnt_q, bnc_cnt_d;
  logic        bnc_en_q, bnc_en_d;
  logic        a_q, a_d;
  logic        b_q, b_d;
  logic        pos_q, pos_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  throws_q, throws_d;

  logic [15:0] lfsr_val;
  logic [15:0] bnc_load;
  logic        phase_zero;
  logic        bnc_last;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .q     (lfsr_val)
  );

  assign bnc_load   = bounce_len(lfsr_val, BOUNCE_W) - 16'h0001;
  assign phase_zero = (phase_q == 16'h0000);
  assign bnc_last   = ((bnc_cnt_q + 4'd1) == BOUNCES_N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= 16'h0000;
      bnc_cnt_q <= 4'd0;
      bnc_en_q  <= 1'b0;
      a_q       <= CLOSED;
      b_q       <= OPEN;
      pos_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      throws_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bnc_cnt_q <= bnc_cnt_d;
      bnc_en_q  <= bnc_en_d;
      a_q       <= a_d;
      b_q       <= b_d;
      pos_q     <= pos_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      throws_q  <= throws_d;
    end
  end

  // Next state: every timed state counts phase down to zero, then moves on.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bnc_cnt_d = bnc_cnt_q;
    bnc_en_d  = bnc_en_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = TRANSIT;
          phase_d   = TRANSIT_LOAD;
          bnc_cnt_d = 4'd0;
          bnc_en_d  = bounce_en;
        end
      end
      TRANSIT: begin
        if (!phase_zero) begin
          phase_d = phase_q - 16'h0001;
        end else if (bnc_en_q && (BOUNCES_N != 4'd0)) begin
          state_d = BNC_CLOSED;
          phase_d = bnc_load;
        end else begin
          state_d = SETTLE;
          phase_d = SETTLE_LOAD;
        end
      end
      BNC_CLOSED: begin
        if (!phase_zero) begin
          phase_d = phase_q - 16'h0001;
        end else begin
          state_d = BNC_OPEN;
          phase_d = bnc_load;
        end
      end
      BNC_OPEN: begin
        if (!phase_zero) begin
          phase_d = phase_q - 16'h0001;
        end else begin
          bnc_cnt_d = bnc_cnt_q + 4'd1;
          if (bnc_last) begin
            state_d = SETTLE;
            phase_d = SETTLE_LOAD;
          end else begin
            state_d = BNC_CLOSED;
            phase_d = bnc_load;
          end
        end
      end
      SETTLE: begin
        if (!phase_zero) begin
          phase_d = phase_q - 16'h0001;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: pos_q names the closed contact, so the other one is the closer.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    pos_d    = pos_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    throws_d = throws_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (pos_q) begin
            b_d = OPEN;
          end else begin
            a_d = OPEN;
          end
        end
      end
      TRANSIT, BNC_OPEN: begin
        if (phase_zero) begin
          if (pos_q) begin
            a_d = CLOSED;
          end else begin
            b_d = CLOSED;
          end
        end
      end
      BNC_CLOSED: begin
        if (phase_zero) begin
          if (pos_q) begin
            a_d = OPEN;
          end else begin
            b_d = OPEN;
          end
        end
      end
      SETTLE: begin
        if (phase_zero) begin
          pos_d    = ~pos_q;
          throws_d = throws_q + 4'd1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  assign a      = a_q;
  assign b      = b_q;
  assign pos    = pos_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign throws = throws_q;

endmodule

`default_nettype wire
